// File: rtl/sum_accum_if.sv
// Valid/ready bundle between the adder stage, the sum_accum block and its result consumer.
// master = producer/consumer side, slave = sum_accum side.
interface sum_accum_if #(
  parameter int unsigned IN_W  = 3,
  parameter int unsigned ACC_W = 8,
  parameter int unsigned WIN   = 4
);
  localparam int unsigned CNT_W = $clog2(WIN + 1);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_o1;
  logic [IN_W-1:0]  in_o2;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum1;
  logic [ACC_W-1:0] out_sum2;
  logic [CNT_W-1:0] out_cnt;
  logic             out_ovf;

  modport master (
    output in_valid, in_o1, in_o2, flush, out_ready,
    input  in_ready, out_valid, out_sum1, out_sum2, out_cnt, out_ovf
  );

  modport slave (
    input  in_valid, in_o1, in_o2, flush, out_ready,
    output in_ready, out_valid, out_sum1, out_sum2, out_cnt, out_ovf
  );
endinterface

// File: rtl/sum_accum.sv
// Windowed accumulator for (o1, o2) adder-stage pairs; emits one result beat per window or flush.
// Optional macro SUM_ACCUM_CHECK_EN adds a sticky chk_err output flagging o2 != o1 + 1.
module sum_accum #(
  parameter int unsigned IN_W  = 3,
  parameter int unsigned ACC_W = 8,
  parameter int unsigned WIN   = 4
) (
  input  logic       clock,
  input  logic       reset,
  sum_accum_if.slave bus
`ifdef SUM_ACCUM_CHECK_EN
  ,
  output logic       chk_err
`endif
);

  localparam int unsigned CNT_W = $clog2(WIN + 1);
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] WinCnt = CNT_W'(WIN);

  typedef enum logic [0:0] {StAcc, StHold} state_e;

  state_e           state_q;
  logic [ACC_W-1:0] acc1_q;
  logic [ACC_W-1:0] acc2_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  logic             accept;
  logic [SUM_W-1:0] sum1;
  logic [SUM_W-1:0] sum2;
  logic [CNT_W-1:0] cnt_inc;
  logic             close_win;

  always_comb begin
    accept  = bus.in_valid && bus.in_ready;
    // One extra bit on each adder exposes the carry out of the accumulator.
    sum1    = {1'b0, acc1_q} + SUM_W'(bus.in_o1);
    sum2    = {1'b0, acc2_q} + SUM_W'(bus.in_o2);
    cnt_inc = cnt_q + CNT_W'(1);
    // A flush only closes a window that will hold at least one sample.
    close_win = (accept && (cnt_inc == WinCnt)) ||
                (bus.flush && (accept || (cnt_q != '0)));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StAcc;
      acc1_q  <= '0;
      acc2_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StAcc: begin
          if (accept) begin
            acc1_q <= sum1[ACC_W-1:0];
            acc2_q <= sum2[ACC_W-1:0];
            cnt_q  <= cnt_inc;
            ovf_q  <= ovf_q | sum1[ACC_W] | sum2[ACC_W];
          end
          if (close_win) begin
            state_q <= StHold;
          end
        end
        StHold: begin
          if (bus.out_ready) begin
            state_q <= StAcc;
            acc1_q  <= '0;
            acc2_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
          end
        end
        default: state_q <= StAcc;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StAcc) && !reset;
  assign bus.out_valid = (state_q == StHold);
  assign bus.out_sum1  = acc1_q;
  assign bus.out_sum2  = acc2_q;
  assign bus.out_cnt   = cnt_q;
  assign bus.out_ovf   = ovf_q;

`ifdef SUM_ACCUM_CHECK_EN
  logic [IN_W-1:0] o1_inc;

  assign o1_inc = bus.in_o1 + IN_W'(1);

  // Sticky until reset; the window handshake leaves it alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      chk_err <= 1'b0;
    end else if (accept && (bus.in_o2 != o1_inc)) begin
      chk_err <= 1'b1;
    end
  end
`endif

`ifndef SYNTHESIS
  // A stalled result beat must not change until the consumer takes it.
  property p_hold_stable;
    @(posedge clock) disable iff (reset)
      (bus.out_valid && !bus.out_ready) |=>
        (bus.out_valid && $stable(bus.out_sum1) && $stable(bus.out_sum2) &&
         $stable(bus.out_cnt) && $stable(bus.out_ovf));
  endproperty
  a_hold_stable: assert property (p_hold_stable);
`endif

endmodule

// File: tb/tb_sum_accum.sv
// Bench for sum_accum: an 8-bit and a 4-bit accumulator instance share one stimulus stream and
// are compared every cycle against a window model built from unbounded integer totals.
module tb_sum_accum;
  localparam int unsigned WIN = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] in_o1 = '0;
  logic [2:0] in_o2 = '0;
  logic       chk8;
  logic       chk4;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  sum_accum_if #(.IN_W(3), .ACC_W(8), .WIN(WIN)) bus8 ();
  sum_accum_if #(.IN_W(3), .ACC_W(4), .WIN(WIN)) bus4 ();

  assign bus8.in_valid  = in_valid;
  assign bus8.in_o1     = in_o1;
  assign bus8.in_o2     = in_o2;
  assign bus8.flush     = flush;
  assign bus8.out_ready = out_ready;
  assign bus4.in_valid  = in_valid;
  assign bus4.in_o1     = in_o1;
  assign bus4.in_o2     = in_o2;
  assign bus4.flush     = flush;
  assign bus4.out_ready = out_ready;

  sum_accum #(.IN_W(3), .ACC_W(8), .WIN(WIN)) dut8 (
    .clock (clock),
    .reset (reset),
    .bus   (bus8)
`ifdef SUM_ACCUM_CHECK_EN
    ,
    .chk_err (chk8)
`endif
  );

  sum_accum #(.IN_W(3), .ACC_W(4), .WIN(WIN)) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (bus4)
`ifdef SUM_ACCUM_CHECK_EN
    ,
    .chk_err (chk4)
`endif
  );

`ifndef SUM_ACCUM_CHECK_EN
  assign chk8 = 1'b0;
  assign chk4 = 1'b0;
`endif

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Window model: unbounded totals of what was accepted; widths only applied on compare.
  bit m_hold = 0;
  bit m_acc = 0;
  bit m_chk = 0;
  bit started = 0;
  int m_t1 = 0;
  int m_t2 = 0;
  int m_n = 0;

  always @(posedge clock) begin
    started = 1;
    m_acc = 0;
    if (reset) begin
      m_hold = 0; m_t1 = 0; m_t2 = 0; m_n = 0; m_chk = 0;
    end else if (!m_hold) begin
      if (in_valid) begin
        m_acc = 1;
        m_t1 += int'(in_o1);
        m_t2 += int'(in_o2);
        m_n++;
        if (int'(in_o2) != ((int'(in_o1) + 1) % 8)) m_chk = 1;
      end
      if ((m_acc && m_n == WIN) || (flush && m_n > 0)) m_hold = 1;
    end else if (out_ready) begin
      m_hold = 0; m_t1 = 0; m_t2 = 0; m_n = 0;
    end
  end

  always @(negedge clock) begin
    if (started) begin
      check("in_ready_w8", bus8.in_ready, !m_hold && !reset);
      check("in_ready_w4", bus4.in_ready, !m_hold && !reset);
      check("out_valid_w8", bus8.out_valid, m_hold);
      check("out_valid_w4", bus4.out_valid, m_hold);
      check("sum1_w8", bus8.out_sum1, m_t1 % 256);
      check("sum2_w8", bus8.out_sum2, m_t2 % 256);
      check("sum1_w4", bus4.out_sum1, m_t1 % 16);
      check("sum2_w4", bus4.out_sum2, m_t2 % 16);
      check("cnt_w8", bus8.out_cnt, m_n);
      check("cnt_w4", bus4.out_cnt, m_n);
      check("ovf_w8", bus8.out_ovf, (m_t1 >= 256) || (m_t2 >= 256));
      check("ovf_w4", bus4.out_ovf, (m_t1 >= 16) || (m_t2 >= 16));
`ifdef SUM_ACCUM_CHECK_EN
      check("chk_err_w8", chk8, m_chk);
      check("chk_err_w4", chk4, m_chk);
`endif
    end
  end

  task automatic cyc(input logic v, input logic [2:0] a, input logic [2:0] b,
                     input logic fl, input logic rdy);
    in_valid = v; in_o1 = a; in_o2 = b; flush = fl; out_ready = rdy;
    @(posedge clock);
    #1;
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("rst_valid", bus8.out_valid, 0);
    check("rst_cnt", bus8.out_cnt, 0);
    reset = 1'b0;
    #1;
    check("rst_ready", bus8.in_ready, 1);

    // Full window of (6,7).
    repeat (4) cyc(1, 6, 7, 0, 1);
    check("t1_valid", bus8.out_valid, 1);
    check("t1_sum1", bus8.out_sum1, 24);
    check("t1_sum2", bus8.out_sum2, 28);
    check("t1_cnt", bus8.out_cnt, 4);
    check("t1_ovf", bus8.out_ovf, 0);
    check("t1_ovf_w4", bus4.out_ovf, 1);
    cyc(0, 0, 0, 0, 1);
    check("t1_ready_after", bus8.in_ready, 1);

    // Wrap in the 4-bit instance.
    repeat (4) cyc(1, 7, 0, 0, 1);
    check("t2_sum1_w4", bus4.out_sum1, 12);
    check("t2_sum2_w4", bus4.out_sum2, 0);
    check("t2_ovf_w4", bus4.out_ovf, 1);
    check("t2_sum1_w8", bus8.out_sum1, 28);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 2, 0, 1);
    check("t2_ovf_cleared", bus4.out_ovf, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1);

    // Flush of a partial window, then backpressure with a waiting producer.
    cyc(1, 1, 2, 0, 0);
    cyc(1, 2, 3, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check("t3_valid", bus8.out_valid, 1);
    check("t3_cnt", bus8.out_cnt, 2);
    check("t3_sum1", bus8.out_sum1, 3);
    check("t3_sum2", bus8.out_sum2, 5);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 5, 6, 0, 0);
      check("t4_ready_stall", bus8.in_ready, 0);
      check("t4_sum1_stall", bus8.out_sum1, 3);
    end
    cyc(1, 5, 6, 0, 1);
    check("t4_ready_resume", bus8.in_ready, 1);
    check("t4_valid_drop", bus8.out_valid, 0);
    cyc(1, 5, 6, 0, 1);
    check("t4_cnt_resume", bus8.out_cnt, 1);
    check("t4_sum1_resume", bus8.out_sum1, 5);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1);
    check("t3_empty_flush", bus8.out_valid, 0);
    cyc(0, 0, 0, 0, 1);
    check("t3_empty_flush2", bus8.out_valid, 0);

    // Reset mid-window discards the partial window.
    repeat (3) cyc(1, 3, 4, 0, 1);
    check("t5_cnt_pre", bus8.out_cnt, 3);
    reset = 1'b1;
    cyc(0, 0, 0, 0, 1);
    check("t5_cnt_rst", bus8.out_cnt, 0);
    check("t5_sum_rst", bus8.out_sum1, 0);
    check("t5_valid_rst", bus8.out_valid, 0);
    reset = 1'b0;
    repeat (4) cyc(1, 1, 2, 0, 1);
    check("t5_sum1", bus8.out_sum1, 4);
    check("t5_sum2", bus8.out_sum2, 8);
    cyc(0, 0, 0, 0, 1);

`ifdef SUM_ACCUM_CHECK_EN
    cyc(1, 3, 4, 0, 1);
    check("t6_chk_ok", chk8, 0);
    cyc(1, 3, 3, 0, 1);
    check("t6_chk_set", chk8, 1);
    repeat (2) cyc(1, 1, 2, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check("t6_chk_sticky", chk8, 1);
    reset = 1'b1;
    cyc(0, 0, 0, 0, 1);
    check("t6_chk_rst", chk8, 0);
    reset = 1'b0;
`endif

    // Random traffic; the producer holds a pending pair until it is taken.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (!(in_valid && !m_acc)) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_o1 = 3'($urandom);
        in_o2 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'(in_o1 + 3'd1);
      end
      flush = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    cyc(0, 0, 0, 0, 1);
    @(negedge clock);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
